// File: rtl/racetrack_defines_pkg.sv
// -----------------------------------------------------------------------------
// racetrack_defines
// Shared types and constants for the racetrack shift-pulse controller.
//   shift_state_t    : controller FSM states
//   SHIFT_DIR_*      : encoding of the shift direction register / shift_dir_o
//   DEF_*_CYCLES     : default pulse-high and gap lengths in clock cycles
//   TIMER_WIDTH      : width of the phase counter (holds up to 15 cycles)
// -----------------------------------------------------------------------------
package racetrack_defines;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE_HI = 2'd1,
    ST_PULSE_LO = 2'd2,
    ST_DONE     = 2'd3
  } shift_state_t;

  localparam logic SHIFT_DIR_SET   = 1'b1;  // move data toward the port
  localparam logic SHIFT_DIR_RESET = 1'b0;  // move data back

  localparam int DEF_PULSE_CYCLES = 2;
  localparam int DEF_GAP_CYCLES   = 1;
  localparam int TIMER_WIDTH      = 4;

endpackage

// File: rtl/racetrack_pulse_timer.sv
// -----------------------------------------------------------------------------
// racetrack_pulse_timer
// Phase counter for the pulse-high / gap phases. Loading value V makes the
// phase last V+1 cycles: expire_o is high in the last cycle of the phase.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   load_i        load load_val_i this cycle (takes priority over counting)
//   load_val_i    phase length minus one
//   expire_o      counter at zero (last cycle of the current phase)
// -----------------------------------------------------------------------------
module racetrack_pulse_timer
  import racetrack_defines::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [TIMER_WIDTH-1:0] load_val_i,
  output logic                   expire_o
);

  logic [TIMER_WIDTH-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/racetrack_shift_ctrl.sv
// -----------------------------------------------------------------------------
// racetrack_shift_ctrl
// Shift-pulse controller downstream of the racetrack access FSM. On a set or
// reset shift request it issues n current pulses (PULSE_CYCLES high, then
// GAP_CYCLES low each) and flags completion with a one-cycle done.
//   clk_i, rst_i          clock, asynchronous active-high reset
//   shift_en_s_i          request set shifts (toward the port)
//   shift_en_r_i          request reset shifts (back)
//   shift_select_i        gate on shift_pulse_o
//   source_shift_sel_i    reset count source: 0 = n_shift_i, 1 = n_sampled
//   n_shift_i             requested shift count
//   shift_pulse_o         shift current pulse
//   shift_dir_o           1 = set, 0 = reset
//   shift_done_s_o/_r_o   one-cycle completion flags
//   busy_o                not IDLE
//   n_sampled_o           count captured at the last set start
//   protocol_err_o        one-cycle flag: both enables high in IDLE
// -----------------------------------------------------------------------------
module racetrack_shift_ctrl
  import racetrack_defines::*;
#(
  parameter int CNT_WIDTH    = 10,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 shift_en_s_i,
  input  logic                 shift_en_r_i,
  input  logic                 shift_select_i,
  input  logic                 source_shift_sel_i,
  input  logic [CNT_WIDTH-1:0] n_shift_i,
  output logic                 shift_pulse_o,
  output logic                 shift_dir_o,
  output logic                 shift_done_s_o,
  output logic                 shift_done_r_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] n_sampled_o,
  output logic                 protocol_err_o
);

  localparam logic [TIMER_WIDTH-1:0] PULSE_LOAD = TIMER_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] GAP_LOAD   = TIMER_WIDTH'(GAP_CYCLES - 1);

  shift_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_WIDTH-1:0]   n_sampled_q, n_sampled_d;
  logic                   dir_q, dir_d;
  logic                   err_q, err_d;
  logic                   tmr_load;
  logic [TIMER_WIDTH-1:0] tmr_val;
  logic                   tmr_expire;
  logic                   active_en;
  logic [CNT_WIDTH-1:0]   start_cnt;

  racetrack_pulse_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  // The enable that keeps the running operation alive.
  assign active_en = (dir_q == SHIFT_DIR_SET) ? shift_en_s_i : shift_en_r_i;

  // Count loaded at start: a set always takes n_shift_i; a reset may replay
  // the count captured by the preceding set.
  assign start_cnt = (shift_en_s_i || !source_shift_sel_i) ? n_shift_i : n_sampled_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    n_sampled_d = n_sampled_q;
    dir_d       = dir_q;
    err_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (shift_en_s_i && shift_en_r_i) begin
          err_d = 1'b1;
        end else if (shift_en_s_i || shift_en_r_i) begin
          if (shift_en_s_i) n_sampled_d = n_shift_i;
          dir_d    = shift_en_s_i ? SHIFT_DIR_SET : SHIFT_DIR_RESET;
          rem_d    = start_cnt;
          state_d  = (start_cnt == '0) ? ST_DONE : ST_PULSE_HI;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end
      end

      ST_PULSE_HI, ST_PULSE_LO: begin
        if (!active_en) begin
          // Abort: drop the operation silently and clear the counters.
          state_d  = ST_IDLE;
          rem_d    = '0;
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          tmr_load = 1'b1;
          if (state_q == ST_PULSE_HI) begin
            state_d = ST_PULSE_LO;
            tmr_val = GAP_LOAD;
          end else begin
            // rem_q is nonzero here, so the decrement cannot wrap.
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q == CNT_WIDTH'(1)) ? ST_DONE : ST_PULSE_HI;
            tmr_val = PULSE_LOAD;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      n_sampled_q <= '0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      n_sampled_q <= n_sampled_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
    end
  end

  // Outputs decode registered state only; the gate is the single input path.
  assign shift_pulse_o  = (state_q == ST_PULSE_HI) && shift_select_i;
  assign shift_dir_o    = dir_q;
  assign shift_done_s_o = (state_q == ST_DONE) && (dir_q == SHIFT_DIR_SET);
  assign shift_done_r_o = (state_q == ST_DONE) && (dir_q == SHIFT_DIR_RESET);
  assign busy_o         = (state_q != ST_IDLE);
  assign n_sampled_o    = n_sampled_q;
  assign protocol_err_o = err_q;

endmodule
